laplace_window_gen: RTL
=======================

Name: laplace_window_gen

Overview:
Streaming neighbourhood generator that sits directly upstream of laplace_aproximado_2. It accepts 8-bit grayscale pixels in raster order, one per handshake, and buffers two image lines. For every interior pixel it emits the 5-point cross window (b, d, e, f, h), which drives the Laplacian stage unchanged. Its output order is identical to the interior-pixel sweep used by the existing filter bench, so filtered-output files are comparable line for line.

Parameters:
ROWS, 512, image height in pixels
COLS, 512, image width in pixels; line buffers are COLS bytes each
PIX_W, 8, pixel width in bits

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_pixel is valid
in_ready  out  1  block can accept a pixel this cycle
in_pixel  in  PIX_W  raster-order pixel
out_valid  out  1  window outputs are valid
out_ready  in  1  downstream accepts the window
b  out  PIX_W  pixel above centre
d  out  PIX_W  pixel left of centre
e  out  PIX_W  centre pixel
f  out  PIX_W  pixel right of centre
h  out  PIX_W  pixel below centre
frame_done  out  1  one-cycle pulse when the last window of the frame is accepted downstream

Behaviour:
- Reset is async, active-low: clk and rst_n.
- On reset: out_valid=0, b/d/e/f/h=0, frame_done=0, row/col counters=0, in_ready=1.
- Line-buffer RAM contents are not cleared; they are never read before being rewritten in a new frame.
- Input transfer: in_valid && in_ready at a rising edge. Pixel (r,c) is written; col increments and wraps at COLS-1 to 0. row increments on that wrap and wraps at ROWS-1 to 0. The next frame then starts with no idle cycle.
- Emit rule: accepting pixel (r,c) with r>=2 and 1<=c<=COLS-2 loads the window centred at (r-1,c):
  - b=(r-2,c)
  - d=(r-1,c-1)
  - e=(r-1,c)
  - f=(r-1,c+1)
  - h=(r,c)=in_pixel
- Timing: out_valid and the window registers are updated at the same edge that accepts the pixel, giving a latency of 1 cycle from acceptance.
- Window count: exactly (ROWS-2)*(COLS-2) windows per frame, in row-major centre order.
- Output register is single-entry: in_ready = !out_valid || out_ready. Full-throughput streaming requires no bubbles.
- Output hold: while out_valid && !out_ready, b/d/e/f/h and out_valid hold stable and no input is accepted.
- out_valid falls after an output transfer (out_valid && out_ready) unless a new window is loaded on the same edge.
- Non-emitting pixels (rows 0-1, columns 0 and COLS-1) are still accepted whenever in_ready=1. They are written into the buffers and do not set out_valid.
- frame_done pulses for 1 cycle on the output transfer of the window centred at (ROWS-2, COLS-2).
- Simultaneous output transfer and emitting input: the new window replaces the old one and out_valid stays 1.
- Reset mid-frame: the frame is aborted. The next accepted pixel is treated as (0,0).
- No arithmetic is performed; all outputs are raw PIX_W-bit copies.

Optional Feature:
Macro LAPLACE_WIN_EOL_EN.
- Defined: adds output port out_eol (1 bit, reset 0). It is registered with the window and is 1 when the window centre column is COLS-2. It holds under backpressure exactly like b..h. A downstream writer uses it to insert row breaks.
- Undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Shared package laplace_pkg:
  - PIX_W default
  - ROWS/COLS defaults (512)
  - derived counter widths $clog2(ROWS), $clog2(COLS)
  - a pixel typedef
- One natural sub-module, laplace_line_buffer: a COLS-deep single-port-write, registered-read delay line. It is instantiated twice, for row r-1 and row r-2.
- The counters, emit logic and output register stay in the top module.

Test Plan:
- ROWS=4, COLS=4, pixels 0..15, out_ready=1 -> exactly 4 windows, in this order:
  - (b,d,e,f,h) = (1,4,5,6,9)
  - (2,5,6,7,10)
  - (5,8,9,10,13)
  - (6,9,10,11,14)
  - frame_done pulses once, with the last window.
- Same stimulus, out_ready held 0 for 5 cycles after the first window -> window (1,4,5,6,9) stays stable, in_ready=0, no pixel is lost, and the subsequent sequence is unchanged.
- Two back-to-back frames (values 0..15, then 100..115) -> second frame windows are (101,104,105,106,109) onward, with no first-frame data leaking.
- Assert rst_n low after pixel 9 accepted, then restart with 0..15 -> all outputs 0 during reset, then exactly 4 correct windows.
- Full 512x512 image.txt with random out_ready -> 510*510 windows. Feeding laplace_aproximado_2, output matches the golden imageFiltered.txt bit for bit.
- With LAPLACE_WIN_EOL_EN, 4x4 stimulus -> out_eol sequence 0,1,0,1.

Source files
------------

// File: rtl/laplace_pkg.sv
// Shared defaults and types for the Laplacian window generator.
// Optional build macro: LAPLACE_WIN_EOL_EN (adds the out_eol row-break flag).
package laplace_pkg;
    localparam int PIX_W_DEF = 8;
    localparam int ROWS_DEF  = 512;
    localparam int COLS_DEF  = 512;
    localparam int ROW_W_DEF = $clog2(ROWS_DEF);
    localparam int COL_W_DEF = $clog2(COLS_DEF);

    typedef logic [PIX_W_DEF-1:0] pixel_t;
endpackage

// File: rtl/laplace_line_buffer.sv
// One image line of storage: column-addressed write, registered read that
// only advances when the owner strobes rd_en, so it holds under backpressure.
module laplace_line_buffer
    import laplace_pkg::*;
#(
    parameter int DEPTH  = COLS_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data
);
    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PIX_W-1:0] rd_data_q;
    logic [PIX_W-1:0] rd_data_d;

    // Storage is never cleared; it is always rewritten before it is consumed.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/laplace_window_gen.sv
// Raster-order pixel stream in, 5-point cross window (b,d,e,f,h) out for every
// interior pixel. Optional macro LAPLACE_WIN_EOL_EN adds the out_eol port.
module laplace_window_gen
    import laplace_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] e,
    output logic [PIX_W-1:0] f,
    output logic [PIX_W-1:0] h,
`ifdef LAPLACE_WIN_EOL_EN
    output logic             out_eol,
`endif
    output logic             frame_done
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] COL_PEN = COL_W'(COLS - 2);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [PIX_W-1:0] d_tap_q, d_tap_d, e_tap_q, e_tap_d;
    logic [PIX_W-1:0] b_q, b_d, d_q, d_d, e_q, e_d, f_q, f_d, h_q, h_d;
    logic             out_valid_q, out_valid_d;
    logic             last_q, last_d;
    logic             eol_q, eol_d;
    logic             accept, emit;
    logic [COL_W-1:0] col_inc, rd1_addr;
    logic [PIX_W-1:0] lb1_rd, lb2_rd;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign emit     = accept && (row_q >= ROW_W'(2)) && (col_q != '0) && (col_q != COL_MAX);

    // lb1 (row r-1) is read two columns ahead so its output is the f tap and
    // shifts into e/d; lb2 (row r-2) is read one column ahead as the b tap.
    assign col_inc  = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
    assign rd1_addr = (col_inc == COL_MAX) ? '0 : col_inc + 1'b1;

    laplace_line_buffer #(.DEPTH(COLS), .PIX_W(PIX_W), .ADDR_W(COL_W)) u_lb1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(accept), .wr_addr(col_q), .wr_data(in_pixel),
        .rd_en(accept), .rd_addr(rd1_addr), .rd_data(lb1_rd)
    );

    laplace_line_buffer #(.DEPTH(COLS), .PIX_W(PIX_W), .ADDR_W(COL_W)) u_lb2 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(accept), .wr_addr(col_q), .wr_data(e_tap_q),
        .rd_en(accept), .rd_addr(col_inc), .rd_data(lb2_rd)
    );

    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        d_tap_d     = d_tap_q;
        e_tap_d     = e_tap_q;
        b_d         = b_q;
        d_d         = d_q;
        e_d         = e_q;
        f_d         = f_q;
        h_d         = h_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        eol_d       = eol_q;
        if (accept) begin
            col_d   = col_inc;
            d_tap_d = e_tap_q;
            e_tap_d = lb1_rd;
            if (col_q == COL_MAX) row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
        end
        if (emit) begin
            b_d         = lb2_rd;
            d_d         = d_tap_q;
            e_d         = e_tap_q;
            f_d         = lb1_rd;
            h_d         = in_pixel;
            out_valid_d = 1'b1;
            last_d      = (row_q == ROW_MAX) && (col_q == COL_PEN);
            eol_d       = (col_q == COL_PEN);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q       <= '0;
            col_q       <= '0;
            d_tap_q     <= '0;
            e_tap_q     <= '0;
            b_q         <= '0;
            d_q         <= '0;
            e_q         <= '0;
            f_q         <= '0;
            h_q         <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            eol_q       <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            d_tap_q     <= d_tap_d;
            e_tap_q     <= e_tap_d;
            b_q         <= b_d;
            d_q         <= d_d;
            e_q         <= e_d;
            f_q         <= f_d;
            h_q         <= h_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            eol_q       <= eol_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign b          = b_q;
    assign d          = d_q;
    assign e          = e_q;
    assign f          = f_q;
    assign h          = h_q;
    assign frame_done = out_valid_q && out_ready && last_q;
`ifdef LAPLACE_WIN_EOL_EN
    assign out_eol    = eol_q;
`else
    logic unused_eol;
    assign unused_eol = eol_q;
`endif
endmodule
